// File: rtl/bpu_pkg.sv
// Shared definitions for the gshare branch predictor: 2-bit counter encodings
// and the saturating counter update.
package bpu_pkg;

   localparam int CTR_W = 2;

   typedef enum logic [CTR_W-1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_e;

   function automatic logic [CTR_W-1:0] ctr_next(input logic [CTR_W-1:0] state,
                                                  input logic             taken);
      logic [CTR_W-1:0] nxt;
      nxt = state;
      case (state)
         SNT:     nxt = taken ? WNT : SNT;
         WNT:     nxt = taken ? WT  : SNT;
         WT:      nxt = taken ? ST  : WNT;
         ST:      nxt = taken ? ST  : WT;
         default: nxt = state;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/bpu_btb.sv
// Tagged direct-mapped branch target buffer: combinational read port,
// single synchronous write port, asynchronous clear of all entries.
module bpu_btb import bpu_pkg::*; #(
   parameter int INDEX_W = 4,
   parameter int TAG_W   = 26
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [INDEX_W-1:0] rd_idx,
   input  logic [TAG_W-1:0]   rd_tag,
   output logic               rd_hit,
   output logic [31:0]        rd_target,
   input  logic               wr_en,
   input  logic [INDEX_W-1:0] wr_idx,
   input  logic [TAG_W-1:0]   wr_tag,
   input  logic [31:0]        wr_target
);

   localparam int unsigned ENTRIES = 1 << INDEX_W;

   logic [ENTRIES-1:0] valid;
   logic [TAG_W-1:0]   tags    [ENTRIES];
   logic [31:0]        targets [ENTRIES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= '0;
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            tags[i]    <= '0;
            targets[i] <= '0;
         end
      end else if (wr_en) begin
         valid[wr_idx]   <= 1'b1;
         tags[wr_idx]    <= wr_tag;
         targets[wr_idx] <= wr_target;
      end
   end

   // Reads see pre-write contents; a same-cycle write lands for the next read.
   always_comb begin
      rd_hit    = valid[rd_idx] && (tags[rd_idx] == rd_tag);
      rd_target = targets[rd_idx];
   end

endmodule

// File: rtl/gshare_bpu.sv
// gshare predictor top: PHT of 2-bit counters, speculative GHR with repair,
// index hashing, BTB instance and registered prediction outputs to Fetch.
module gshare_bpu import bpu_pkg::*; #(
   parameter int               INDEX_W  = 4,
   parameter int               GHR_W    = 4,
   parameter logic [CTR_W-1:0] CTR_INIT = 2'b01
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             if_valid,
   input  logic [31:0]      if_pc,
   output logic             pred_valid,
   output logic             pred_taken,
   output logic [31:0]      pred_target,
   output logic [GHR_W-1:0] pred_ghr,
   input  logic             ex_valid,
   input  logic [31:0]      ex_pc,
   input  logic [GHR_W-1:0] ex_ghr,
   input  logic             ex_taken,
   input  logic [31:0]      ex_target,
   input  logic             ex_mispredict
);

   localparam int          TAG_W   = 30 - INDEX_W;
   localparam int unsigned ENTRIES = 1 << INDEX_W;

   logic [GHR_W-1:0]   ghr;
   logic [CTR_W-1:0]   pht [ENTRIES];

   logic [INDEX_W-1:0] if_idx;
   logic [TAG_W-1:0]   if_tag;
   logic [INDEX_W-1:0] ex_idx;
   logic [TAG_W-1:0]   ex_tag;
   logic [CTR_W-1:0]   if_ctr;
   logic               btb_hit;
   logic [31:0]        btb_target;
   logic               lookup_taken;
   logic               unused_pc_lsbs;

   assign unused_pc_lsbs = ^{if_pc[1:0], ex_pc[1:0]};

   always_comb begin
      if_idx       = if_pc[INDEX_W+1:2] ^ INDEX_W'(ghr);
      if_tag       = if_pc[31:INDEX_W+2];
      ex_idx       = ex_pc[INDEX_W+1:2] ^ INDEX_W'(ex_ghr);
      ex_tag       = ex_pc[31:INDEX_W+2];
      if_ctr       = pht[if_idx];
      lookup_taken = btb_hit & if_ctr[CTR_W-1];
   end

   bpu_btb #(
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W)
   ) u_btb (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_idx    (if_idx),
      .rd_tag    (if_tag),
      .rd_hit    (btb_hit),
      .rd_target (btb_target),
      .wr_en     (ex_valid),
      .wr_idx    (ex_idx),
      .wr_tag    (ex_tag),
      .wr_target (ex_target)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            pht[i] <= CTR_INIT;
         end
      end else if (ex_valid) begin
         pht[ex_idx] <= ctr_next(pht[ex_idx], ex_taken);
      end
   end

   // Repair from Execute wins over a same-cycle speculative shift.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ghr <= '0;
      end else if (ex_valid && ex_mispredict) begin
         ghr <= {ex_ghr[GHR_W-2:0], ex_taken};
      end else if (if_valid && btb_hit) begin
         ghr <= {ghr[GHR_W-2:0], if_ctr[CTR_W-1]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pred_valid  <= 1'b0;
         pred_taken  <= 1'b0;
         pred_target <= '0;
         pred_ghr    <= '0;
      end else begin
         pred_valid <= if_valid;
         if (if_valid) begin
            pred_taken  <= lookup_taken;
            pred_target <= lookup_taken ? btb_target : if_pc + 32'd4;
            pred_ghr    <= ghr;
         end
      end
   end

endmodule

// File: tb/tb_gshare_bpu.sv
// Directed scoreboard bench for gshare_bpu: stimulus pushes expected predictions,
// a negedge monitor pops and compares whenever pred_valid is presented.
module tb_gshare_bpu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_valid;
   logic [31:0] if_pc;
   logic        pred_valid;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic [3:0]  pred_ghr;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic [3:0]  ex_ghr;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        ex_mispredict;

   always #5 clk = ~clk;

   gshare_bpu #(
      .INDEX_W  (4),
      .GHR_W    (4),
      .CTR_INIT (2'b01)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .if_valid      (if_valid),
      .if_pc         (if_pc),
      .pred_valid    (pred_valid),
      .pred_taken    (pred_taken),
      .pred_target   (pred_target),
      .pred_ghr      (pred_ghr),
      .ex_valid      (ex_valid),
      .ex_pc         (ex_pc),
      .ex_ghr        (ex_ghr),
      .ex_taken      (ex_taken),
      .ex_target     (ex_target),
      .ex_mispredict (ex_mispredict)
   );

   typedef struct {
      int          id;
      logic        taken;
      logic [31:0] target;
      logic [3:0]  ghr;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   next_id  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (pred_valid === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_pred: pred_valid got 1 expected 0 (no lookup outstanding)");
            end else begin
               e = sb.pop_front();
               chk($sformatf("lookup%0d_taken", e.id), {31'd0, pred_taken}, {31'd0, e.taken});
               chk($sformatf("lookup%0d_target", e.id), pred_target, e.target);
               chk($sformatf("lookup%0d_ghr", e.id), {28'd0, pred_ghr}, {28'd0, e.ghr});
            end
         end
      end
   end

   task automatic lookup(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic [3:0] g);
      exp_t e;
      if_valid = 1'b1;
      if_pc    = pc;
      e.id     = next_id;
      e.taken  = tk;
      e.target = tgt;
      e.ghr    = g;
      next_id++;
      sb.push_back(e);
   endtask

   task automatic train(input logic [31:0] pc, input logic [3:0] g, input logic tk,
                        input logic [31:0] tgt, input logic mis);
      ex_valid      = 1'b1;
      ex_pc         = pc;
      ex_ghr        = g;
      ex_taken      = tk;
      ex_target     = tgt;
      ex_mispredict = mis;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if_valid      = 1'b0;
      ex_valid      = 1'b0;
      ex_mispredict = 1'b0;
   endtask

   initial begin : stimulus
      rst_n = 1'b0;
      if_valid = 1'b0; if_pc = '0;
      ex_valid = 1'b0; ex_pc = '0; ex_ghr = '0; ex_taken = 1'b0; ex_target = '0;
      ex_mispredict = 1'b0;
      #2;
      chk("rst_valid",  {31'd0, pred_valid}, 32'd0);
      chk("rst_taken",  {31'd0, pred_taken}, 32'd0);
      chk("rst_target", pred_target, 32'd0);
      chk("rst_ghr",    {28'd0, pred_ghr}, 32'd0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      // Train idx 0 and hit it, then reset asynchronously while the prediction is live
      train(32'h100, 4'h0, 1'b1, 32'h200, 1'b0); tick();
      lookup(32'h100, 1'b1, 32'h200, 4'h0); tick();
      @(negedge clk); #2;
      chk("prereset_valid", {31'd0, pred_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid",  {31'd0, pred_valid}, 32'd0);
      chk("midrst_taken",  {31'd0, pred_taken}, 32'd0);
      chk("midrst_target", pred_target, 32'd0);
      chk("midrst_ghr",    {28'd0, pred_ghr}, 32'd0);
      @(posedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      lookup(32'h100, 1'b0, 32'h104, 4'h0); tick();

      // Basic train then hit; GHR shifts to 0001, observed via next lookup
      train(32'h100, 4'h0, 1'b1, 32'h200, 1'b0); tick();
      lookup(32'h100, 1'b1, 32'h200, 4'h0); tick();
      lookup(32'h140, 1'b0, 32'h144, 4'h1); tick();

      // Saturation at ST, then decrement; mispredict repairs reset GHR to 0000
      repeat (4) begin
         train(32'h100, 4'h0, 1'b1, 32'h200, 1'b0); tick();
      end
      train(32'h100, 4'h0, 1'b0, 32'h200, 1'b1); tick();
      lookup(32'h100, 1'b1, 32'h200, 4'h0); tick();
      train(32'h100, 4'h0, 1'b0, 32'h200, 1'b0); tick();
      train(32'h100, 4'h0, 1'b0, 32'h200, 1'b1); tick();
      lookup(32'h100, 1'b0, 32'h104, 4'h0); tick();

      // Repair beats a same-cycle speculative shift
      train(32'h100, 4'h0, 1'b1, 32'h200, 1'b0); tick();
      train(32'h100, 4'h0, 1'b1, 32'h200, 1'b0); tick();
      lookup(32'h100, 1'b1, 32'h200, 4'h0);
      train(32'h108, 4'h0, 1'b0, 32'h300, 1'b1); tick();

      // Tag alias on idx 0 misses and leaves GHR unchanged
      lookup(32'h140, 1'b0, 32'h144, 4'h0); tick();
      lookup(32'h140, 1'b0, 32'h144, 4'h0); tick();

      // Collision: lookup reads pre-update WNT, next lookup sees WT
      train(32'h100, 4'h0, 1'b0, 32'h200, 1'b0); tick();
      lookup(32'h100, 1'b0, 32'h104, 4'h0);
      train(32'h100, 4'h0, 1'b1, 32'h200, 1'b0); tick();
      lookup(32'h100, 1'b1, 32'h200, 4'h0); tick();

      // Idle cycle: pred_valid drops, other outputs hold
      tick();
      @(negedge clk);
      chk("idle_valid",  {31'd0, pred_valid}, 32'd0);
      chk("idle_taken",  {31'd0, pred_taken}, 32'd1);
      chk("idle_target", pred_target, 32'h200);
      chk("idle_ghr",    {28'd0, pred_ghr}, 32'd0);
      @(posedge clk); #1;

      // PC+4 wraps at the top of the address space
      lookup(32'hFFFF_FFFC, 1'b0, 32'h0, 4'h1); tick();

      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
